// File: rtl/ifid_fetch_stage.sv
// Instruction fetch with PC, imem req/ack handshake and an IF/ID register.
// A one-entry skid buffer absorbs the word that arrives while decode stalls.
module ifid_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] Instr,
    output logic [15:0] Imm16,
    output logic [7:0]  Imm8,
    output logic        EXTOp
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        id_valid_n;
    entry_t      id_q, id_n;
    entry_t      hold, hold_n;
    logic        slot_free;
    logic [31:0] redir_tgt;

    assign slot_free = !id_valid || id_ready;
    assign redir_tgt = redir_pc & ~32'h3;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        id_valid_n = id_valid;
        id_n       = id_q;
        hold_n     = hold;
        if (state != IDLE && redir_valid) begin
            // Redirect wins over ack and consume alike.
            pc_n       = redir_tgt;
            id_valid_n = 1'b0;
            state_n    = REQ;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redir_valid) pc_n = redir_tgt;
                    state_n = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_n = pc + PC_STEP;
                        if (slot_free) begin
                            id_n       = '{pc: pc, instr: imem_rdata};
                            id_valid_n = 1'b1;
                        end else begin
                            hold_n  = '{pc: pc, instr: imem_rdata};
                            state_n = HOLD;
                        end
                    end else if (id_ready) begin
                        id_valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (id_ready) begin
                        id_n    = hold;
                        state_n = REQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_q     <= '0;
            hold     <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            id_valid <= id_valid_n;
            id_q     <= id_n;
            hold     <= hold_n;
        end
    end

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign id_pc     = id_q.pc;
    assign Instr     = id_q.instr;
    assign Imm16     = Instr[15:0];
    assign Imm8      = Instr[7:0];

    // Logical immediates zero-extend; everything else sign-extends.
    always_comb begin
        EXTOp = 1'b1;
        unique case (Instr[31:26])
            6'h0C, 6'h0D, 6'h0E, 6'h0F: EXTOp = 1'b0;
            default:                    EXTOp = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Directed bench for ifid_fetch_stage against a 0-wait instruction memory.
// Each task drives one scenario and checks its own expected values.
module tb_ifid_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = '0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] Instr;
    logic [15:0] Imm16;
    logic [7:0]  Imm8;
    logic        EXTOp;
    logic        mem_en = 1'b0;

    int passed = 0;
    int total = 0;

    ifid_fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .id_ready(id_ready), .id_valid(id_valid),
        .id_pc(id_pc), .Instr(Instr),
        .Imm16(Imm16), .Imm8(Imm8), .EXTOp(EXTOp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_3000: mem_word = 32'h3C01_1234;
            32'h0000_3004: mem_word = 32'h2408_FFF0;
            32'h0000_3008: mem_word = 32'h3108_00F0;
            default:       mem_word = 32'h2400_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    always_comb begin
        imem_ack   = mem_en & imem_req;
        imem_rdata = mem_word(imem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0) $display("FAIL rst_valid got %h want 0", id_valid); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %h want 0", imem_req); else passed++;
        total++; if (Instr !== 32'h0) $display("FAIL rst_instr got %h want 0", Instr); else passed++;
        total++; if (id_pc !== 32'h0) $display("FAIL rst_idpc got %h want 0", id_pc); else passed++;
        total++; if (imem_addr !== 32'h3000) $display("FAIL rst_addr got %h want 3000", imem_addr); else passed++;
        total++; if ({Imm16, Imm8} !== 24'h0) $display("FAIL rst_imm got %h want 0", {Imm16, Imm8}); else passed++;
        tick();
        rst = 1'b1;
        mem_en = 1'b1;
        id_ready = 1'b1;
        tick();
        total++; if (imem_req !== 1'b1) $display("FAIL idle_to_req got %h want 1", imem_req); else passed++;
        total++; if (id_valid !== 1'b0) $display("FAIL idle_valid got %h want 0", id_valid); else passed++;
    endtask

    task automatic test_stream();
        tick();
        total++; if (id_valid !== 1'b1) $display("FAIL s0_valid got %h want 1", id_valid); else passed++;
        total++; if (Instr !== 32'h3C01_1234) $display("FAIL s0_instr got %h want 3c011234", Instr); else passed++;
        total++; if (Imm16 !== 16'h1234) $display("FAIL s0_imm16 got %h want 1234", Imm16); else passed++;
        total++; if (EXTOp !== 1'b0) $display("FAIL s0_extop got %h want 0", EXTOp); else passed++;
        total++; if (id_pc !== 32'h3000) $display("FAIL s0_idpc got %h want 3000", id_pc); else passed++;
        total++; if (imem_addr !== 32'h3004) $display("FAIL s0_addr got %h want 3004", imem_addr); else passed++;
        tick();
        total++; if (EXTOp !== 1'b1) $display("FAIL s1_extop got %h want 1", EXTOp); else passed++;
        total++; if (Imm16 !== 16'hFFF0) $display("FAIL s1_imm16 got %h want fff0", Imm16); else passed++;
        total++; if (Imm8 !== 8'hF0) $display("FAIL s1_imm8 got %h want f0", Imm8); else passed++;
        total++; if (imem_addr !== 32'h3008) $display("FAIL s1_addr got %h want 3008", imem_addr); else passed++;
        tick();
        total++; if (EXTOp !== 1'b0) $display("FAIL s2_extop got %h want 0", EXTOp); else passed++;
        total++; if (Imm8 !== 8'hF0) $display("FAIL s2_imm8 got %h want f0", Imm8); else passed++;
        total++; if (id_pc !== 32'h3008) $display("FAIL s2_idpc got %h want 3008", id_pc); else passed++;
    endtask

    task automatic test_stall();
        mem_en = 1'b0;
        tick();
        total++; if (id_valid !== 1'b0) $display("FAIL drain_valid got %h want 0", id_valid); else passed++;
        total++; if (imem_addr !== 32'h300C) $display("FAIL drain_addr got %h want 300c", imem_addr); else passed++;
        mem_en = 1'b1;
        id_ready = 1'b0;
        tick();
        total++; if (id_pc !== 32'h300C) $display("FAIL st0_idpc got %h want 300c", id_pc); else passed++;
        tick();
        total++; if (imem_req !== 1'b0) $display("FAIL hold_req got %h want 0", imem_req); else passed++;
        total++; if (imem_addr !== 32'h3014) $display("FAIL hold_addr got %h want 3014", imem_addr); else passed++;
        total++; if (id_pc !== 32'h300C) $display("FAIL hold_idpc got %h want 300c", id_pc); else passed++;
        tick();
        total++; if (imem_req !== 1'b0) $display("FAIL hold2_req got %h want 0", imem_req); else passed++;
        total++; if (Instr !== 32'h2400_300C) $display("FAIL hold2_instr got %h want 2400300c", Instr); else passed++;
        total++; if (id_valid !== 1'b1) $display("FAIL hold2_valid got %h want 1", id_valid); else passed++;
        id_ready = 1'b1;
        tick();
        total++; if (id_pc !== 32'h3010) $display("FAIL unh_idpc got %h want 3010", id_pc); else passed++;
        total++; if (Instr !== 32'h2400_3010) $display("FAIL unh_instr got %h want 24003010", Instr); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL unh_req got %h want 1", imem_req); else passed++;
        total++; if (imem_addr !== 32'h3014) $display("FAIL unh_addr got %h want 3014", imem_addr); else passed++;
        tick();
        total++; if (id_pc !== 32'h3014) $display("FAIL b2b_idpc got %h want 3014", id_pc); else passed++;
    endtask

    task automatic test_redirect();
        redir_valid = 1'b1;
        redir_pc = 32'h0000_4007;
        tick();
        redir_valid = 1'b0;
        total++; if (imem_addr !== 32'h4004) $display("FAIL rd_addr got %h want 4004", imem_addr); else passed++;
        total++; if (id_valid !== 1'b0) $display("FAIL rd_valid got %h want 0", id_valid); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL rd_req got %h want 1", imem_req); else passed++;
        tick();
        total++; if (id_pc !== 32'h4004) $display("FAIL rd_idpc got %h want 4004", id_pc); else passed++;
        id_ready = 1'b0;
        tick();
        total++; if (imem_req !== 1'b0) $display("FAIL rdh_req got %h want 0", imem_req); else passed++;
        redir_valid = 1'b1;
        id_ready = 1'b1;
        tick();
        redir_valid = 1'b0;
        total++; if (id_valid !== 1'b0) $display("FAIL rdh_valid got %h want 0", id_valid); else passed++;
        total++; if (imem_addr !== 32'h4004) $display("FAIL rdh_addr got %h want 4004", imem_addr); else passed++;
        tick();
        total++; if (id_pc !== 32'h4004) $display("FAIL rdh_idpc got %h want 4004", id_pc); else passed++;
        total++; if (imem_addr !== 32'h4008) $display("FAIL rdh_next got %h want 4008", imem_addr); else passed++;
    endtask

    task automatic test_wrap();
        redir_valid = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wr_addr got %h want fffffffc", imem_addr); else passed++;
        tick();
        total++; if (imem_addr !== 32'h0) $display("FAIL wr_next got %h want 0", imem_addr); else passed++;
        total++; if (id_pc !== 32'hFFFF_FFFC) $display("FAIL wr_idpc got %h want fffffffc", id_pc); else passed++;
    endtask

    task automatic test_async_reset();
        tick();
        total++; if (id_valid !== 1'b1) $display("FAIL ar_pre got %h want 1", id_valid); else passed++;
        rst = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0) $display("FAIL ar_valid got %h want 0", id_valid); else passed++;
        total++; if (Instr !== 32'h0) $display("FAIL ar_instr got %h want 0", Instr); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL ar_req got %h want 0", imem_req); else passed++;
        #2 rst = 1'b1;
        tick();
        total++; if (imem_addr !== 32'h3000) $display("FAIL ar_addr got %h want 3000", imem_addr); else passed++;
        total++; if (imem_req !== 1'b1) $display("FAIL ar_req2 got %h want 1", imem_req); else passed++;
        tick();
        total++; if (Instr !== 32'h3C01_1234) $display("FAIL ar_instr2 got %h want 3c011234", Instr); else passed++;
        total++; if (id_pc !== 32'h3000) $display("FAIL ar_idpc got %h want 3000", id_pc); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
